multicycle_controller: RTL

Multicycle successor to the single-cycle MIPS controller. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-memory datapath's enables and mux selects. It adds three things:
- a memory ready/wait handshake;
- optional BNE support;
- overflow-trapping writeback suppression and illegal-instruction detection.

It sits between the instruction register and the multicycle datapath.

---
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller. This is a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback. It adds a memory ready handshake,
// optional BNE, overflow-suppressed writeback and illegal-opcode trapping.
//
// state  | meaning
// -------+-----------------------------------------------
// 0  FETCH  | read instruction at PC, PC <= PC+4 on ready
// 1  DECODE | branch target into ALUOut, dispatch on opcode
// 2  MEMADR | effective address for lw/sw
// 3  MEMRD  | data read, wait for mem_ready
// 4  MEMWB  | MDR -> rt
// 5  MEMWR  | data write, wait for mem_ready
// 6  EXEC   | R-type ALU op, capture overflow
// 7  ALUWB  | ALUOut -> rd unless overflow trapped
// 8  BRANCH | compare, conditional PC <= ALUOut
// 9  ADDIEX | regA + imm, capture overflow
// 10 ADDIWB | ALUOut -> rt unless overflow trapped
// 11 JUMP   | PC <= jump target
// 12 TRAP   | illegal instruction pulse
module multicycle_controller #(
  parameter int ALUCTRL_W   = 4,
  parameter bit ENABLE_BNE  = 1'b1,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 overflow,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic                 ovf_trap,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;

  state_t     state, state_nxt;
  logic       ovf_q;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic [3:0] alu_op;
  logic       mem_re_d, mem_we_d, ir_we_d, pc_we_d, reg_we_d, illegal_d, ovf_trap_d;

  // R-type funct decode: supported flag and ALU operation
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b100111:            funct_alu = ALU_NOR;
      6'b101010:            funct_alu = ALU_SLT;
      default:              funct_ok  = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_nxt = funct_ok ? S_EXEC : S_TRAP;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_BNE:        state_nxt = ENABLE_BNE ? S_BRANCH : S_TRAP;
          OP_ADDI:       state_nxt = S_ADDIEX;
          OP_J:          state_nxt = S_JUMP;
          default:       state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State register and captured overflow flag for the writeback cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC)
        ovf_q <= overflow & TRAP_ON_OVF & ((funct == F_ADD) | (funct == F_SUB));
      else if (state == S_ADDIEX)
        ovf_q <= overflow & TRAP_ON_OVF;
      else if (state_nxt == S_FETCH)
        ovf_q <= 1'b0;
    end
  end

  // Moore output decode (plus the mem_ready/zero qualifiers)
  always_comb begin
    iord       = 1'b0;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    ir_we_d    = 1'b0;
    pc_we_d    = 1'b0;
    reg_we_d   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    illegal_d  = 1'b0;
    ovf_trap_d = 1'b0;
    case (state)
      S_FETCH: begin
        mem_re_d  = 1'b1;
        alu_src_b = 2'b01;
        ir_we_d   = mem_ready;
        pc_we_d   = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_re_d = 1'b1;
      end
      S_MEMWB: begin
        reg_we_d   = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_we_d = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_we_d   = ~ovf_q;
        ovf_trap_d = ovf_q;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_we_d   = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_we_d   = ~ovf_q;
        ovf_trap_d = ovf_q;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_we_d = 1'b1;
      end
      S_TRAP:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  // Reset holds state in FETCH, so the enables must be squashed separately
  assign mem_re      = mem_re_d   & rst_n;
  assign mem_we      = mem_we_d   & rst_n;
  assign ir_we       = ir_we_d    & rst_n;
  assign pc_we       = pc_we_d    & rst_n;
  assign reg_we      = reg_we_d   & rst_n;
  assign illegal     = illegal_d  & rst_n;
  assign ovf_trap    = ovf_trap_d & rst_n;
  assign alu_control = ALUCTRL_W'(alu_op);
  assign state_o     = state;

endmodule
